// File: rtl/memory_isa_pkg.sv
// Shared ISA definitions for the controller -> memory instruction interface:
// opcode encoding, instruction field bounds, executor states and sizing helpers.
package memory_isa_pkg;

    // Opcode encoding shared with the controller. 0xF is unassigned and runs as a NOP.
    typedef enum logic [3:0] {
        OP_NOP       = 4'h0,
        OP_END       = 4'h1,
        OP_XOR       = 4'h2,
        OP_ADDI      = 4'h3,
        OP_BGE       = 4'h4,
        OP_JUMP      = 4'h5,
        OP_LOADB     = 4'h6,
        OP_OR        = 4'h7,
        OP_SENDITERS = 4'h8,
        OP_SMA       = 4'h9,
        OP_LOADI     = 4'hA,
        OP_LOAD      = 4'hB,
        OP_SENDL     = 4'hC,
        OP_WRITEB    = 4'hD,
        OP_WRITE     = 4'hE
    } opcode_e;

    // Executor FSM states; the register is exported for observation.
    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_RD_ISSUE   = 2'd1,
        ST_RD_WAIT    = 2'd2,
        ST_RD_CAPTURE = 2'd3
    } exec_state_e;

    // Field bounds in the big-endian [0:31] instruction numbering (bit 0 = MSB).
    localparam int OP_FIRST  = 0;
    localparam int OP_LAST   = 3;
    localparam int RA_FIRST  = 4;
    localparam int RA_LAST   = 7;
    localparam int IMM_FIRST = 8;
    localparam int IMM_LAST  = 23;
    localparam int RB_FIRST  = 24;
    localparam int RB_LAST   = 27;
    localparam int RC_FIRST  = 28;
    localparam int RC_LAST   = 31;

    // One line carries a,b,c for every FMA; word k sits at bits [k*word_width +: word_width].
    function automatic int line_width(input int fma_count, input int word_width);
        return fma_count * 3 * word_width;
    endfunction

    function automatic int addr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/line_buffer.sv
// One-line temporary buffer. Applies LOADI (single word) and LOAD (strided
// ramp across FMAs) writes, each with its own bounds check.
module line_buffer
    import memory_isa_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FMA_COUNT  = 4,
    localparam int LINE_WIDTH = line_width(FMA_COUNT, DATA_WIDTH)
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  loadi_we_in,
    input  logic                  load_we_in,
    input  logic [3:0]            ra_in,
    input  logic [15:0]           imm_in,
    input  logic [DATA_WIDTH-1:0] base_in,
    output logic [LINE_WIDTH-1:0] line_out
);

    localparam int WORDS = FMA_COUNT * 3;

    logic [LINE_WIDTH-1:0] line_d, line_q;

    // Next line: LOADI writes word ra when it exists; LOAD writes slot ra of every FMA when ra is a valid slot.
    always_comb begin
        line_d = line_q;
        if (loadi_we_in && (int'(ra_in) < WORDS)) begin
            line_d[int'(ra_in)*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(imm_in);
        end else if (load_we_in && (ra_in <= 4'd2)) begin
            for (int i = 0; i < FMA_COUNT; i++) begin
                line_d[(3*i + int'(ra_in))*DATA_WIDTH +: DATA_WIDTH] =
                    base_in + DATA_WIDTH'(i) * DATA_WIDTH'(imm_in);
            end
        end
    end

    // Line register, cleared by reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) line_q <= '0;
        else        line_q <= line_d;
    end

    assign line_out = line_q;

endmodule

// File: rtl/memory_instr_executor.sv
// Memory-side instruction executor: decodes memory opcodes, drives the
// data-cache port and emits one-cycle operand lines to the FMA array.
//
// Handshake: an instruction transfers on a rising edge where instr_valid_in
// and ready_out are both 1. ready_out is 1 only in IDLE; while it is 0 the
// controller holds instr_in/reg_*_in stable with instr_valid_in asserted.
module memory_instr_executor
    import memory_isa_pkg::*;
#(
    parameter int INSTRUCTION_WIDTH = 32,
    parameter int PRIVATE_REG_WIDTH = 16,
    parameter int DATA_CACHE_WIDTH  = 16,
    parameter int DATA_CACHE_DEPTH  = 4096,
    parameter int FMA_COUNT         = 4,
    localparam int ADDR_W     = addr_width(DATA_CACHE_DEPTH),
    localparam int LINE_WIDTH = line_width(FMA_COUNT, DATA_CACHE_WIDTH)
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic [0:INSTRUCTION_WIDTH-1] instr_in,
    input  logic [PRIVATE_REG_WIDTH-1:0] reg_a_in,
    input  logic [PRIVATE_REG_WIDTH-1:0] reg_b_in,
    input  logic [PRIVATE_REG_WIDTH-1:0] reg_c_in,
    input  logic                         instr_valid_in,
    output logic                         ready_out,
    output logic [ADDR_W-1:0]            cache_addr_out,
    output logic [LINE_WIDTH-1:0]        cache_wdata_out,
    output logic                         cache_we_out,
    output logic                         cache_en_out,
    input  logic [LINE_WIDTH-1:0]        cache_rdata_in,
    output logic [LINE_WIDTH-1:0]        fma_line_out,
    output logic                         fma_replace_c_out,
    output logic                         fma_output_en_out,
    output logic                         fma_valid_out,
    output logic [ADDR_W-1:0]            mem_addr_out,
    output exec_state_e                  state_out
);

    opcode_e     op;
    logic [3:0]  ra, rb, rc;
    logic [15:0] imm;
    logic        accept;
    logic [LINE_WIDTH-1:0] line;

    exec_state_e           state_d, state_q;
    logic [ADDR_W-1:0]     mem_addr_d, mem_addr_q;
    logic [ADDR_W-1:0]     cache_addr_d, cache_addr_q;
    logic [LINE_WIDTH-1:0] cache_wdata_d, cache_wdata_q;
    logic                  cache_we_d, cache_we_q;
    logic                  cache_en_d, cache_en_q;
    logic [LINE_WIDTH-1:0] fma_line_d, fma_line_q;
    logic                  fma_replace_d, fma_replace_q;
    logic                  fma_out_en_d, fma_out_en_q;
    logic                  fma_valid_d, fma_valid_q;
    logic                  pend_replace_d, pend_replace_q;
    logic                  pend_out_en_d, pend_out_en_q;

    assign op     = opcode_e'(instr_in[OP_FIRST:OP_LAST]);
    assign ra     = instr_in[RA_FIRST:RA_LAST];
    assign imm    = instr_in[IMM_FIRST:IMM_LAST];
    assign rb     = instr_in[RB_FIRST:RB_LAST];
    assign rc     = instr_in[RC_FIRST:RC_LAST];
    assign accept = instr_valid_in && (state_q == ST_IDLE);

    // Operands not consumed by any memory opcode.
    logic unused_ok;
    assign unused_ok = ^{reg_a_in, reg_c_in, rc};

    line_buffer #(
        .DATA_WIDTH (DATA_CACHE_WIDTH),
        .FMA_COUNT  (FMA_COUNT)
    ) u_line_buffer (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .loadi_we_in (accept && (op == OP_LOADI)),
        .load_we_in  (accept && (op == OP_LOAD)),
        .ra_in       (ra),
        .imm_in      (imm),
        .base_in     (DATA_CACHE_WIDTH'(reg_b_in)),
        .line_out    (line)
    );

    // Next-state and registered-output logic; strobes default low, data outputs hold.
    always_comb begin
        state_d        = state_q;
        mem_addr_d     = mem_addr_q;
        cache_addr_d   = cache_addr_q;
        cache_wdata_d  = cache_wdata_q;
        cache_we_d     = 1'b0;
        cache_en_d     = 1'b0;
        fma_line_d     = fma_line_q;
        fma_replace_d  = fma_replace_q;
        fma_out_en_d   = fma_out_en_q;
        fma_valid_d    = 1'b0;
        pend_replace_d = pend_replace_q;
        pend_out_en_d  = pend_out_en_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (op)
                        OP_SMA: mem_addr_d = imm[ADDR_W-1:0];
                        OP_SENDL: begin
                            cache_en_d    = 1'b1;
                            cache_we_d    = 1'b1;
                            cache_addr_d  = imm[ADDR_W-1:0];
                            cache_wdata_d = line;
                        end
                        OP_WRITE: begin
                            fma_line_d    = line;
                            fma_valid_d   = 1'b1;
                            fma_replace_d = (ra != 4'd0);
                            fma_out_en_d  = (rb != 4'd0);
                        end
                        OP_WRITEB: begin
                            state_d        = ST_RD_ISSUE;
                            cache_en_d     = 1'b1;
                            cache_addr_d   = imm[ADDR_W-1:0];
                            pend_replace_d = (ra != 4'd0);
                            pend_out_en_d  = (rb != 4'd0);
                        end
                        default: ;
                    endcase
                end
            end
            ST_RD_ISSUE: begin
                cache_en_d = 1'b1;
                state_d    = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                cache_en_d = 1'b1;
                state_d    = ST_RD_CAPTURE;
            end
            ST_RD_CAPTURE: begin
                fma_line_d    = cache_rdata_in;
                fma_valid_d   = 1'b1;
                fma_replace_d = pend_replace_q;
                fma_out_en_d  = pend_out_en_q;
                state_d       = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset aborts any in-flight read.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q        <= ST_IDLE;
            mem_addr_q     <= '0;
            cache_addr_q   <= '0;
            cache_wdata_q  <= '0;
            cache_we_q     <= 1'b0;
            cache_en_q     <= 1'b0;
            fma_line_q     <= '0;
            fma_replace_q  <= 1'b0;
            fma_out_en_q   <= 1'b0;
            fma_valid_q    <= 1'b0;
            pend_replace_q <= 1'b0;
            pend_out_en_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            mem_addr_q     <= mem_addr_d;
            cache_addr_q   <= cache_addr_d;
            cache_wdata_q  <= cache_wdata_d;
            cache_we_q     <= cache_we_d;
            cache_en_q     <= cache_en_d;
            fma_line_q     <= fma_line_d;
            fma_replace_q  <= fma_replace_d;
            fma_out_en_q   <= fma_out_en_d;
            fma_valid_q    <= fma_valid_d;
            pend_replace_q <= pend_replace_d;
            pend_out_en_q  <= pend_out_en_d;
        end
    end

    assign ready_out         = (state_q == ST_IDLE);
    assign cache_addr_out    = cache_addr_q;
    assign cache_wdata_out   = cache_wdata_q;
    assign cache_we_out      = cache_we_q;
    assign cache_en_out      = cache_en_q;
    assign fma_line_out      = fma_line_q;
    assign fma_replace_c_out = fma_replace_q;
    assign fma_output_en_out = fma_out_en_q;
    assign fma_valid_out     = fma_valid_q;
    assign mem_addr_out      = mem_addr_q;
    assign state_out         = state_q;

endmodule

// File: tb/tb_memory_instr_executor.sv
// Directed bench for memory_instr_executor with a 2-cycle BRAM model.
module tb_memory_instr_executor;
    import memory_isa_pkg::*;

    localparam int LW = 192;

    logic          clk = 1'b0;
    logic          rst;
    logic [0:31]   instr_in;
    logic [15:0]   reg_a_in, reg_b_in, reg_c_in;
    logic          instr_valid_in;
    logic          ready_out;
    logic [11:0]   cache_addr_out;
    logic [LW-1:0] cache_wdata_out;
    logic          cache_we_out, cache_en_out;
    logic [LW-1:0] cache_rdata_in;
    logic [LW-1:0] fma_line_out;
    logic          fma_replace_c_out, fma_output_en_out, fma_valid_out;
    logic [11:0]   mem_addr_out;
    exec_state_e   state_out;

    int n_vec = 0;
    int n_err = 0;
    int pulses = 0;
    int pulse_base;
    logic [LW-1:0] exp_line;
    logic [LW-1:0] bram [0:4095];
    logic [LW-1:0] rd_pipe;

    memory_instr_executor dut (
        .clk_in            (clk),
        .rst_in            (rst),
        .instr_in          (instr_in),
        .reg_a_in          (reg_a_in),
        .reg_b_in          (reg_b_in),
        .reg_c_in          (reg_c_in),
        .instr_valid_in    (instr_valid_in),
        .ready_out         (ready_out),
        .cache_addr_out    (cache_addr_out),
        .cache_wdata_out   (cache_wdata_out),
        .cache_we_out      (cache_we_out),
        .cache_en_out      (cache_en_out),
        .cache_rdata_in    (cache_rdata_in),
        .fma_line_out      (fma_line_out),
        .fma_replace_c_out (fma_replace_c_out),
        .fma_output_en_out (fma_output_en_out),
        .fma_valid_out     (fma_valid_out),
        .mem_addr_out      (mem_addr_out),
        .state_out         (state_out)
    );

    // Clock and reset
    always #5 clk = ~clk;

    // Data cache: write on en&we, read data appears two cycles after the address
    always @(posedge clk) begin
        if (cache_en_out && cache_we_out) bram[cache_addr_out] <= cache_wdata_out;
        if (cache_en_out) rd_pipe <= bram[cache_addr_out];
        cache_rdata_in <= rd_pipe;
    end

    // Count FMA strobes, sampled mid-cycle
    always @(negedge clk) begin
        if (fma_valid_out) pulses <= pulses + 1;
    end

    function automatic logic [31:0] mk(input logic [3:0] op, input logic [3:0] ra,
                                       input logic [15:0] imm, input logic [3:0] rb);
        return {op, ra, imm, rb, 4'h0};
    endfunction

    function automatic logic [LW-1:0] set_w(input logic [LW-1:0] l, input int k, input logic [15:0] v);
        logic [LW-1:0] r;
        r = l;
        r[k*16 +: 16] = v;
        return r;
    endfunction

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Driver: called at a negedge with ready_out=1; returns at the negedge of T+1
    task automatic issue(input logic [31:0] w, input logic [15:0] b);
        instr_in = w;
        reg_b_in = b;
        instr_valid_in = 1'b1;
        @(negedge clk);
        instr_valid_in = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) bram[i] = '0;
        rd_pipe = '0;
        cache_rdata_in = '0;
        rst = 1'b1;
        instr_in = '0;
        reg_a_in = 16'h1111;
        reg_b_in = '0;
        reg_c_in = 16'h2222;
        instr_valid_in = 1'b0;
        exp_line = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_ready", ready_out, 1);
        check("rst_state", state_out, ST_IDLE);
        check("rst_cache", {cache_en_out, cache_we_out, cache_addr_out}, 0);
        check("rst_wdata", cache_wdata_out, 0);
        check("rst_fma_ctl", {fma_valid_out, fma_replace_c_out, fma_output_en_out}, 0);
        check("rst_fma_line", fma_line_out, 0);
        check("rst_mem_addr", mem_addr_out, 0);

        // LOADI word 0 and word 11, then WRITE with both flags
        issue(mk(OP_LOADI, 4'd0, 16'h0100, 4'd0), 16'h0);
        issue(mk(OP_LOADI, 4'd11, 16'hFFFF, 4'd0), 16'h0);
        exp_line = set_w(exp_line, 0, 16'h0100);
        exp_line = set_w(exp_line, 11, 16'hFFFF);
        issue(mk(OP_WRITE, 4'd1, 16'h0, 4'd1), 16'h0);
        check("write_valid", fma_valid_out, 1);
        check("write_line", fma_line_out, exp_line);
        check("write_flags", {fma_replace_c_out, fma_output_en_out}, 2'b11);
        @(negedge clk);
        check("write_valid_drop", fma_valid_out, 0);
        check("write_line_hold", fma_line_out, exp_line);
        issue(mk(OP_WRITE, 4'd0, 16'h0, 4'd0), 16'h0);
        check("write_flags0", {fma_valid_out, fma_replace_c_out, fma_output_en_out}, 3'b100);

        // LOAD ra=1 ramp, LOAD ra=3 ignored, LOAD ra=2 with wrap
        issue(mk(OP_LOAD, 4'd1, 16'h0004, 4'd0), 16'h0010);
        exp_line = set_w(exp_line, 1, 16'h0010);
        exp_line = set_w(exp_line, 4, 16'h0014);
        exp_line = set_w(exp_line, 7, 16'h0018);
        exp_line = set_w(exp_line, 10, 16'h001C);
        issue(mk(OP_WRITE, 4'd0, 16'h0, 4'd0), 16'h0);
        check("load_ramp", fma_line_out, exp_line);
        issue(mk(OP_LOAD, 4'd3, 16'h0001, 4'd0), 16'h1234);
        issue(mk(OP_WRITE, 4'd0, 16'h0, 4'd0), 16'h0);
        check("load_ra3_ignored", fma_line_out, exp_line);
        issue(mk(OP_LOAD, 4'd2, 16'h0008, 4'd0), 16'hFFF0);
        exp_line = set_w(exp_line, 2, 16'hFFF0);
        exp_line = set_w(exp_line, 5, 16'hFFF8);
        exp_line = set_w(exp_line, 8, 16'h0000);
        exp_line = set_w(exp_line, 11, 16'h0008);
        issue(mk(OP_WRITE, 4'd0, 16'h0, 4'd0), 16'h0);
        check("load_wrap", fma_line_out, exp_line);

        // SMA keeps only the low address bits
        issue(mk(OP_SMA, 4'd0, 16'hF123, 4'd0), 16'h0);
        check("sma_addr", mem_addr_out, 12'h123);

        // SENDL then back-to-back WRITEB of the same line
        issue(mk(OP_SENDL, 4'd0, 16'h1005, 4'd0), 16'h0);
        check("sendl_strobe", {cache_en_out, cache_we_out, ready_out}, 3'b111);
        check("sendl_addr", cache_addr_out, 12'h005);
        check("sendl_wdata", cache_wdata_out, exp_line);
        pulse_base = pulses;
        issue(mk(OP_WRITEB, 4'd1, 16'h0005, 4'd0), 16'h0);
        check("wb_t1", {cache_en_out, cache_we_out, ready_out}, 3'b100);
        check("wb_t1_addr", cache_addr_out, 12'h005);
        check("wb_t1_state", state_out, ST_RD_ISSUE);
        @(negedge clk);
        check("wb_t2", {cache_en_out, cache_we_out, ready_out, fma_valid_out}, 4'b1000);
        @(negedge clk);
        check("wb_t3", {cache_en_out, cache_we_out, ready_out, fma_valid_out}, 4'b1000);
        check("wb_t3_addr", cache_addr_out, 12'h005);
        @(negedge clk);
        check("wb_t4", {cache_en_out, ready_out, fma_valid_out}, 3'b011);
        check("wb_t4_line", fma_line_out, exp_line);
        check("wb_t4_flags", {fma_replace_c_out, fma_output_en_out}, 2'b10);
        repeat (2) @(negedge clk);
        check("wb_one_pulse", pulses - pulse_base, 1);

        // WRITEB with a SENDL held from RD_WAIT: SENDL transfers at T+4
        pulse_base = pulses;
        issue(mk(OP_WRITEB, 4'd0, 16'h0005, 4'd1), 16'h0);
        check("hold_t1_ready", ready_out, 0);
        @(negedge clk);
        instr_in = mk(OP_SENDL, 4'd0, 16'h0009, 4'd0);
        instr_valid_in = 1'b1;
        @(negedge clk);
        check("hold_t3", {ready_out, cache_we_out}, 2'b00);
        @(negedge clk);
        check("hold_t4", {ready_out, fma_valid_out, cache_we_out}, 3'b110);
        check("hold_t4_line", fma_line_out, exp_line);
        check("hold_t4_flags", {fma_replace_c_out, fma_output_en_out}, 2'b01);
        @(negedge clk);
        instr_valid_in = 1'b0;
        check("hold_t5_sendl", {cache_en_out, cache_we_out, fma_valid_out}, 3'b110);
        check("hold_t5_addr", cache_addr_out, 12'h009);
        check("hold_t5_wdata", cache_wdata_out, exp_line);
        repeat (3) @(negedge clk);
        check("hold_one_pulse", pulses - pulse_base, 1);

        // Reset during RD_WAIT aborts the read
        pulse_base = pulses;
        issue(mk(OP_WRITEB, 4'd1, 16'h0009, 4'd1), 16'h0);
        @(negedge clk);
        check("abort_state", state_out, ST_RD_WAIT);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_ready", ready_out, 1);
        check("abort_cache", {cache_en_out, cache_we_out, cache_addr_out}, 0);
        check("abort_wdata", cache_wdata_out, 0);
        check("abort_fma", {fma_valid_out, fma_replace_c_out, fma_output_en_out}, 0);
        check("abort_line", fma_line_out, 0);
        check("abort_mem_addr", mem_addr_out, 0);
        repeat (4) @(negedge clk);
        check("abort_no_pulse", pulses - pulse_base, 0);
        exp_line = '0;
        issue(mk(OP_WRITE, 4'd0, 16'h0, 4'd0), 16'h0);
        check("abort_buf_cleared", fma_line_out, exp_line);

        // Out-of-range LOADI and unknown opcode are single-cycle NOPs
        issue(mk(OP_LOADI, 4'd5, 16'hABCD, 4'd0), 16'h0);
        exp_line = set_w(exp_line, 5, 16'hABCD);
        issue(mk(OP_LOADI, 4'd12, 16'h5555, 4'd0), 16'h0);
        check("loadi12_ready", ready_out, 1);
        check("loadi12_quiet", {cache_en_out, cache_we_out, fma_valid_out}, 0);
        issue(mk(4'hF, 4'd5, 16'h0777, 4'd1), 16'h0);
        check("opf_ready", ready_out, 1);
        check("opf_quiet", {cache_en_out, cache_we_out, fma_valid_out}, 0);
        check("opf_line_hold", fma_line_out, 0);
        issue(mk(OP_LOADB, 4'd2, 16'h0123, 4'd0), 16'h0);
        check("loadb_ready", ready_out, 1);
        issue(mk(OP_WRITE, 4'd0, 16'h0, 4'd0), 16'h0);
        check("nop_line", fma_line_out, exp_line);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
